mult_div_unit: RTL
==================

# mult_div_unit

Iterative multiply/divide unit for the MIPS datapath, sitting directly downstream of the register file: it takes the two register read ports (rs on operand A, rt on operand B) and executes MULT, MULTU, DIV and DIVU into the architectural HI/LO registers. It also services MTHI/MTLO writes. One operation runs at a time, with a fixed 34-edge latency and a busy/done handshake toward the control unit.

## Interface
- No parameters; datapath width fixed at 32 bits.
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  request a new operation; sampled only in IDLE
- operation  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start
- operandA  input  32  rs value, dividend or multiplicand; sampled with start
- operandB  input  32  rt value, divisor or multiplier; sampled with start
- writeHi  input  1  MTHI strobe; HI <= writeData
- writeLo  input  1  MTLO strobe; LO <= writeData
- writeData  input  32  rs value for MTHI/MTLO
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when HI/LO receive a result
- divideByZero  output  1  pulses with done when a DIV/DIVU had operandB == 0
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- Reset values: hi = 0, lo = 0, busy = 0, done = 0, divideByZero = 0, state = IDLE.
- States: IDLE, RUN, FIX.
- IDLE to RUN on an edge with start = 1.
  - Latch the operation.
  - Latch the operand magnitudes. For MULT and DIV this is the two's-complement absolute value; for unsigned operations it is the raw bits.
  - Latch the result sign flags.
  - Clear the iteration counter to 0.
- RUN performs one iteration per edge for 32 edges (counter 0..31), then moves to FIX.
  - Multiply: shift-add, one multiplier bit per iteration, into a 64-bit product.
  - Divide: restoring division, one quotient bit per iteration, with a 33-bit partial remainder.
- FIX applies the sign correction, writes hi/lo, pulses done, and returns to IDLE.
- Multiply result: the 64-bit product is negated if the operand signs differ (MULT only). hi = product[63:32], lo = product[31:0].
- Divide result: lo = quotient, hi = remainder.
  - Signed quotient is negated if the operand signs differ.
  - Signed remainder takes the sign of the dividend.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000 and hi = 0. No trap is raised.
- Divide by zero, signed or unsigned:
  - lo = 0xFFFFFFFF and hi = operandA as latched (raw bits).
  - divideByZero = 1 in the done cycle.
  - Latency is unchanged.
- A start while busy is ignored: no queueing and no effect on the running operation.
- writeHi/writeLo are honoured only in IDLE and are ignored while busy.
  - If write and start occur on the same IDLE edge, the write lands; the later result overwrites it.
- hi/lo hold their value between writes.
- Reset during RUN or FIX aborts the operation. Everything returns to reset values on that edge, and no done is produced.

## Timing
- Edge E0: start accepted in IDLE; busy = 1 after E0.
- Edges E1..E32: iterations; the state is FIX after E32.
- Edge E33: hi/lo updated.
  - After E33: busy = 0, done = 1 (and divideByZero if applicable) for exactly one cycle.
- busy is high for 33 cycles.
- Back-to-back operation: start may be held or re-asserted in the done cycle and is accepted on E34. Throughput is one operation per 34 cycles.
- Operands need only be valid on the start edge; later changes have no effect.
- hi/lo are registered outputs. Consumers read them directly in the done cycle.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001; done exactly 34 edges after start; busy high 33 cycles.
- MULT 0xFFFFFFFD (−3) × 0x00000007 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; then MULT 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0.
- DIV 0xFFFFFFF9 (−7) / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIVU 0x00000064 / 0 → lo = 0xFFFFFFFF, hi = 0x00000064, divideByZero = 1 with done; DIVU 100 / 7 → lo = 14, hi = 2, divideByZero = 0.
- writeLo = 1, writeData = 0x12345678 in IDLE → lo = 0x12345678. While busy, writeHi and a second start are both ignored, and the result of the first operation appears unchanged.
- Reset asserted at iteration 10 of a DIVU → next cycle hi = lo = 0, busy = 0, and no done pulse. A fresh start afterwards completes normally; back-to-back starts in the done cycle complete two operations in 68 edges.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle, sign fix-up in a final cycle, plus MTHI/MTLO writes.
module mult_div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  operation,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic        writeHi,
  input  logic        writeLo,
  input  logic [31:0] writeData,
  output logic        busy,
  output logic        done,
  output logic        divideByZero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  stateDebug
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]  state, nextState;
  logic        isDiv, negMain, negRem, divZero;
  logic [31:0] addend, rawA;
  logic [63:0] work;
  logic [32:0] rem;
  logic [4:0]  count;

  logic        signedOp;
  logic [31:0] absA, absB;
  logic [32:0] mulSum, divShift, divTrial, divRem;
  logic        qBit;
  logic [63:0] prodFinal;
  logic [31:0] quotFinal, remFinal;

  // Operand magnitudes taken at start; unsigned ops keep raw bits.
  assign signedOp = operation[0];
  assign absA = (signedOp && operandA[31]) ? -operandA : operandA;
  assign absB = (signedOp && operandB[31]) ? -operandB : operandB;

  // Multiply keeps the multiplier in work[31:0] and accumulates into work[63:32];
  // divide shifts the dividend out of work[31:0] while quotient bits shift in.
  assign mulSum   = {1'b0, work[63:32]} + (work[0] ? {1'b0, addend} : 33'd0);
  assign divShift = {rem[31:0], work[31]};
  assign divTrial = divShift - {1'b0, addend};
  assign qBit     = ~divTrial[32];
  assign divRem   = qBit ? divTrial : divShift;

  assign prodFinal = negMain ? -work : work;
  assign quotFinal = negMain ? -work[31:0] : work[31:0];
  assign remFinal  = negRem ? -rem[31:0] : rem[31:0];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = RUN;
      RUN:     if (count == 5'd31) nextState = FIX;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    stateDebug = state;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi           <= '0;
      lo           <= '0;
      done         <= 1'b0;
      divideByZero <= 1'b0;
      isDiv        <= 1'b0;
      negMain      <= 1'b0;
      negRem       <= 1'b0;
      divZero      <= 1'b0;
      addend       <= '0;
      rawA         <= '0;
      work         <= '0;
      rem          <= '0;
      count        <= '0;
    end else begin
      case (state)
        IDLE: begin
          done         <= 1'b0;
          divideByZero <= 1'b0;
          if (writeHi) hi <= writeData;
          if (writeLo) lo <= writeData;
          if (start) begin
            isDiv   <= operation[1];
            negMain <= signedOp & (operandA[31] ^ operandB[31]);
            negRem  <= signedOp & operandA[31];
            divZero <= operation[1] & (operandB == '0);
            rawA    <= operandA;
            addend  <= operation[1] ? absB : absA;
            work    <= {32'd0, (operation[1] ? absA : absB)};
            rem     <= '0;
            count   <= '0;
          end
        end
        RUN: begin
          if (isDiv) begin
            rem        <= divRem;
            work[31:0] <= {work[30:0], qBit};
          end else begin
            work <= {mulSum, work[31:1]};
          end
          count <= count + 5'd1;
        end
        FIX: begin
          done         <= 1'b1;
          divideByZero <= divZero;
          if (!isDiv) begin
            hi <= prodFinal[63:32];
            lo <= prodFinal[31:0];
          end else if (divZero) begin
            hi <= rawA;
            lo <= 32'hFFFF_FFFF;
          end else begin
            hi <= remFinal;
            lo <= quotFinal;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
